// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output stage and the SPI register file that feeds it.
// Pin index split: [7:0] drive uo_out, [15:8] drive uio_out.
package pwm_pkg;

  localparam int PWM_DUTY_W          = 8;
  localparam int PWM_NUM_PINS        = 16;
  localparam logic [PWM_DUTY_W-1:0] PWM_DUTY_FULL = 8'hFF;
  localparam int PWM_CLK_DIV_DEFAULT = 13;

  typedef logic [PWM_NUM_PINS-1:0] pin_vec_t;

  // Drive for one pin: disabled pins are low, static pins high, PWM pins follow the level.
  function automatic logic pin_drive(input logic en_o, input logic en_p, input logic level);
    return en_o & (~en_p | level);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler dividing clk by CLK_DIV and a free-running period counter.
// wrap marks the last clk of each period (counter about to step from all-ones to zero).
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT,
  parameter int DUTY_W  = PWM_DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              tick,
  output logic              wrap
);

  localparam logic [7:0]        PRE_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]        PRE_ONE  = 8'd1;
  localparam logic [DUTY_W-1:0] CNT_ONE  = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] CNT_LAST = '1;

  logic [7:0] pre_cnt;

  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick & (pwm_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
      if (tick) begin
        pwm_cnt <= pwm_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pwm_output_stage.sv
// Pad driver: static or common-PWM drive for the 16 chip outputs, with a duty shadow
// register that only updates on the period wrap so a period is never cut short.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT,
  parameter int DUTY_W  = PWM_DUTY_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PWM_NUM_PINS-1:0] en_out,
  input  logic [PWM_NUM_PINS-1:0] en_pwm,
  input  logic [DUTY_W-1:0]       pwm_duty_cycle,
  output logic [PWM_NUM_PINS-1:0] out,
  output logic                    period_start
);

  localparam logic [DUTY_W-1:0] DUTY_FULL = '1;

  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_active;
  logic              wrap;
  logic              tick_unused;
  logic              pwm_level;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV),
    .DUTY_W  (DUTY_W)
  ) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (pwm_cnt),
    .tick    (tick_unused),
    .wrap    (wrap)
  );

  // Full duty is special-cased so the last count step does not produce a one-step low dip.
  assign pwm_level = (duty_active == DUTY_FULL) ? 1'b1 : (pwm_cnt < duty_active);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active  <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      if (wrap) begin
        duty_active <= pwm_duty_cycle;
      end
      for (int i = 0; i < PWM_NUM_PINS; i++) begin
        out[i] <= pin_drive(en_out[i], en_pwm[i], pwm_level);
      end
      period_start <= wrap;
    end
  end

endmodule
